// File: rtl/ay38500_cfg_pkg.sv
// Shared types and constants for the AY-3-8500 configuration sequencer.
// Contents: sequencer state enum, live option payload, game index constants,
// game index clamp and one-hot decode helpers.
package ay38500_cfg_pkg;

    localparam int unsigned NUM_GAMES = 7;
    localparam int unsigned GAME_W    = 3;
    localparam int unsigned OPT_W     = 4;

    localparam logic [GAME_W-1:0] GAME_TENNIS   = 3'd0;
    localparam logic [GAME_W-1:0] GAME_SOCCER   = 3'd1;
    localparam logic [GAME_W-1:0] GAME_HANDICAP = 3'd2;
    localparam logic [GAME_W-1:0] GAME_SQUASH   = 3'd3;
    localparam logic [GAME_W-1:0] GAME_PRACTICE = 3'd4;
    localparam logic [GAME_W-1:0] GAME_RIFLE1   = 3'd5;
    localparam logic [GAME_W-1:0] GAME_RIFLE2   = 3'd6;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        CHIP_RST = 2'd1,
        SETTLE   = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic autoserve;
        logic size;
        logic angle;
        logic speed;
    } cfg_opts_t;

    // Index 7 has no game behind it; it falls back to Tennis.
    function automatic logic [GAME_W-1:0] game_clamp(input logic [GAME_W-1:0] g);
        return (g == 3'd7) ? GAME_TENNIS : g;
    endfunction

    function automatic logic [NUM_GAMES-1:0] game_onehot_of(input logic [GAME_W-1:0] g);
        return 7'd1 << g;
    endfunction

endpackage

// File: rtl/game_config_sequencer_if.sv
// Bundle between the OSD/status side and the configuration sequencer.
// master: drives vsync, user reset and raw option requests, observes outputs.
// slave : the sequencer; drives chip reset, active game and live options.
interface game_config_sequencer_if;
    import ay38500_cfg_pkg::*;

    logic              vs;
    logic              user_reset;
    logic [GAME_W-1:0] req_game;
    logic              req_autoserve;
    logic              req_size;
    logic              req_angle;
    logic              req_speed;

    logic                 chip_reset_n;
    logic [NUM_GAMES-1:0] game_onehot;
    logic                 autoserve;
    logic                 size;
    logic                 angle;
    logic                 speed;
    logic                 busy;

    modport master (
        output vs, user_reset, req_game, req_autoserve, req_size, req_angle, req_speed,
        input  chip_reset_n, game_onehot, autoserve, size, angle, speed, busy
    );

    modport slave (
        input  vs, user_reset, req_game, req_autoserve, req_size, req_angle, req_speed,
        output chip_reset_n, game_onehot, autoserve, size, angle, speed, busy
    );

endinterface

// File: rtl/game_config_sequencer_frame_debounce.sv
// Frame-based debounce: a request that differs from the live value must stay
// unchanged for STABLE_FRAMES vsync rises before commit_c pulses (for one clk,
// on the deciding vsync rise cycle).
// Ports: clk_sys, reset (sync, active-low), req (raw request), cur (live value),
// vs_rise (frame tick), enable (count only while high), commit_c (pulse).
module frame_debounce #(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned WIDTH         = 1
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] cur,
    input  logic             vs_rise,
    input  logic             enable,
    output logic             commit_c
);

    localparam int unsigned       CNT_W    = $clog2(STABLE_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_FRAMES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_FRAMES);

    logic [WIDTH-1:0] req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter tracks frames the current request has been held while differing
    // from the live value; any change, match or disable clears it.
    always_comb begin
        req_d    = req;
        cnt_d    = cnt_q;
        commit_c = 1'b0;
        if (!enable || (req != req_q) || (req == cur)) begin
            cnt_d = '0;
        end else if (vs_rise) begin
            if (cnt_q >= CNT_LAST) begin
                commit_c = 1'b1;
                cnt_d    = CNT_MAX;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            req_q <= '0;
            cnt_q <= '0;
        end else begin
            req_q <= req_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_config_sequencer.sv
// Owns the AY-3-8500 configuration pins and chip reset. Option requests are
// debounced against vsync and applied live; a game change or user reset runs
// a vsync-aligned chip reset -> settle sequence.
// Ports: clk_sys (clock), reset (sync, active-low block reset),
// bus (slave side: vs, user_reset, req_* in; chip_reset_n, game_onehot,
// autoserve/size/angle/speed, busy out). All outputs are registered.
module game_config_sequencer
    import ay38500_cfg_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned RESET_FRAMES  = 2,
    parameter int unsigned SETTLE_FRAMES = 1
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    game_config_sequencer_if.slave bus
);

    localparam int unsigned FRM_MAX = (RESET_FRAMES > SETTLE_FRAMES) ? RESET_FRAMES : SETTLE_FRAMES;
    localparam int unsigned FRM_W   = $clog2(FRM_MAX + 1);
    localparam logic [FRM_W-1:0] RST_LAST = FRM_W'(RESET_FRAMES - 1);
    localparam logic [FRM_W-1:0] SET_LAST = FRM_W'(SETTLE_FRAMES - 1);

    logic                 vs_q, vs_d;
    seq_state_t           state_q, state_d;
    logic [FRM_W-1:0]     frm_q, frm_d;
    logic [GAME_W-1:0]    game_q, game_d;
    logic [GAME_W-1:0]    pending_q, pending_d;
    logic [NUM_GAMES-1:0] onehot_q, onehot_d;
    cfg_opts_t            opts_q, opts_d;
    logic                 chip_reset_n_q, chip_reset_n_d;
    logic                 busy_q, busy_d;

    logic              vs_rise_c;
    logic [GAME_W-1:0] req_game_c;
    cfg_opts_t         req_opts_c;
    logic              dbnc_en_c;
    logic              game_commit_c;
    logic              opts_commit_c;

    // Request decode and frame tick.
    always_comb begin
        vs_rise_c  = bus.vs & ~vs_q;
        req_game_c = game_clamp(bus.req_game);
        req_opts_c = '{autoserve: bus.req_autoserve, size: bus.req_size,
                       angle: bus.req_angle, speed: bus.req_speed};
        dbnc_en_c  = (state_q == RUN);
    end

    frame_debounce #(
        .STABLE_FRAMES (STABLE_FRAMES),
        .WIDTH         (GAME_W)
    ) u_game_dbnc (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .req      (req_game_c),
        .cur      (game_q),
        .vs_rise  (vs_rise_c),
        .enable   (dbnc_en_c),
        .commit_c (game_commit_c)
    );

    frame_debounce #(
        .STABLE_FRAMES (STABLE_FRAMES),
        .WIDTH         (OPT_W)
    ) u_opts_dbnc (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .req      (req_opts_c),
        .cur      (opts_q),
        .vs_rise  (vs_rise_c),
        .enable   (dbnc_en_c),
        .commit_c (opts_commit_c)
    );

    // Sequencer next state and registered outputs.
    always_comb begin
        vs_d      = bus.vs;
        state_d   = state_q;
        frm_d     = frm_q;
        game_d    = game_q;
        pending_d = pending_q;
        onehot_d  = onehot_q;
        opts_d    = opts_q;

        case (state_q)
            RUN: begin
                if (bus.user_reset) begin
                    state_d = CHIP_RST;
                    frm_d   = '0;
                end else begin
                    if (opts_commit_c) begin
                        opts_d = req_opts_c;
                    end
                    if (game_commit_c) begin
                        pending_d = req_game_c;
                        state_d   = CHIP_RST;
                        frm_d     = '0;
                    end
                end
            end
            CHIP_RST: begin
                // A user reset still held at the release edge restarts the hold.
                if (vs_rise_c) begin
                    if (frm_q >= RST_LAST) begin
                        frm_d = '0;
                        if (!bus.user_reset) begin
                            state_d = SETTLE;
                        end
                    end else begin
                        frm_d = frm_q + FRM_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (bus.user_reset) begin
                    state_d = CHIP_RST;
                    frm_d   = '0;
                end else if (vs_rise_c) begin
                    if (frm_q >= SET_LAST) begin
                        state_d = RUN;
                        frm_d   = '0;
                    end else begin
                        frm_d = frm_q + FRM_W'(1);
                    end
                end
            end
            default: begin
                state_d = CHIP_RST;
                frm_d   = '0;
            end
        endcase

        // The active game only moves when a chip reset begins.
        if ((state_d == CHIP_RST) && (state_q != CHIP_RST)) begin
            game_d   = pending_d;
            onehot_d = game_onehot_of(pending_d);
        end

        chip_reset_n_d = (state_d != CHIP_RST);
        busy_d         = (state_d != RUN);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            vs_q           <= 1'b0;
            state_q        <= CHIP_RST;
            frm_q          <= '0;
            game_q         <= GAME_TENNIS;
            pending_q      <= GAME_TENNIS;
            onehot_q       <= 7'b0000001;
            opts_q         <= '0;
            chip_reset_n_q <= 1'b0;
            busy_q         <= 1'b1;
        end else begin
            vs_q           <= vs_d;
            state_q        <= state_d;
            frm_q          <= frm_d;
            game_q         <= game_d;
            pending_q      <= pending_d;
            onehot_q       <= onehot_d;
            opts_q         <= opts_d;
            chip_reset_n_q <= chip_reset_n_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.chip_reset_n = chip_reset_n_q;
    assign bus.game_onehot  = onehot_q;
    assign bus.autoserve    = opts_q.autoserve;
    assign bus.size         = opts_q.size;
    assign bus.angle        = opts_q.angle;
    assign bus.speed        = opts_q.speed;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_game_config_sequencer.sv
// Self-checking bench for game_config_sequencer: frame-level vector table,
// hand sequences for reset corner cases, then randomized requests against a
// frame-level reference model.
module tb_game_config_sequencer;
    import ay38500_cfg_pkg::*;

    localparam int STABLE = 4;
    localparam int RESETF = 2;
    localparam int SETTLF = 1;

    logic clk_sys = 1'b0;
    logic reset;
    game_config_sequencer_if bus();

    game_config_sequencer dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0] game;
        logic [3:0] opts;
        logic       exp_rst_n;
        logic       exp_busy;
        logic [6:0] exp_onehot;
        logic [3:0] exp_opts;
    } vec_t;

    vec_t vecs[31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    function automatic logic [3:0] live_opts();
        return {bus.autoserve, bus.size, bus.angle, bus.speed};
    endfunction

    task automatic check_all(input string tag, input logic rst_n, input logic busy,
                             input logic [6:0] onehot, input logic [3:0] opts);
        check({tag, ".chip_reset_n"}, 32'(bus.chip_reset_n), 32'(rst_n));
        check({tag, ".busy"},         32'(bus.busy),         32'(busy));
        check({tag, ".game_onehot"},  32'(bus.game_onehot),  32'(onehot));
        check({tag, ".opts"},         32'(live_opts()),      32'(opts));
    endtask

    task automatic drive_req(input logic [2:0] g, input logic [3:0] o);
        bus.req_game      = g;
        bus.req_autoserve = o[3];
        bus.req_size      = o[2];
        bus.req_angle     = o[1];
        bus.req_speed     = o[0];
    endtask

    // One 100-clk frame: vs rises 50 clk in; ends mid-frame on a negedge.
    task automatic frame();
        repeat (50) @(negedge clk_sys);
        bus.vs = 1'b1;
        repeat (4) @(negedge clk_sys);
        bus.vs = 1'b0;
        repeat (46) @(negedge clk_sys);
    endtask

    task automatic pulse_user_reset();
        bus.user_reset = 1'b1;
        @(negedge clk_sys);
        bus.user_reset = 1'b0;
    endtask

    function automatic int clampi(input int g);
        return (g == 7) ? 0 : g;
    endfunction

    // Frame-level reference model state.
    int  m_game, m_opts, m_gcnt, m_ocnt, m_rst_seen, m_set_seen;
    bit  m_in_rst, m_in_set;

    initial begin
        bus.vs = 1'b0;
        bus.user_reset = 1'b0;
        drive_req(3'd0, 4'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);
        check_all("por", 1'b0, 1'b1, 7'h01, 4'h0);
        reset = 1'b1;

        vecs[0]  = '{3'd0, 4'h0, 1'b0, 1'b1, 7'h01, 4'h0};
        vecs[1]  = '{3'd0, 4'h0, 1'b1, 1'b1, 7'h01, 4'h0};
        vecs[2]  = '{3'd0, 4'h0, 1'b1, 1'b0, 7'h01, 4'h0};
        vecs[3]  = '{3'd3, 4'h0, 1'b1, 1'b0, 7'h01, 4'h0};
        vecs[4]  = '{3'd3, 4'h0, 1'b1, 1'b0, 7'h01, 4'h0};
        vecs[5]  = '{3'd3, 4'h0, 1'b1, 1'b0, 7'h01, 4'h0};
        vecs[6]  = '{3'd3, 4'h0, 1'b0, 1'b1, 7'h08, 4'h0};
        vecs[7]  = '{3'd3, 4'h0, 1'b0, 1'b1, 7'h08, 4'h0};
        vecs[8]  = '{3'd3, 4'h0, 1'b1, 1'b1, 7'h08, 4'h0};
        vecs[9]  = '{3'd3, 4'h0, 1'b1, 1'b0, 7'h08, 4'h0};
        vecs[10] = '{3'd1, 4'h0, 1'b1, 1'b0, 7'h08, 4'h0};
        vecs[11] = '{3'd2, 4'h0, 1'b1, 1'b0, 7'h08, 4'h0};
        vecs[12] = '{3'd1, 4'h0, 1'b1, 1'b0, 7'h08, 4'h0};
        vecs[13] = '{3'd2, 4'h0, 1'b1, 1'b0, 7'h08, 4'h0};
        vecs[14] = '{3'd2, 4'h0, 1'b1, 1'b0, 7'h08, 4'h0};
        vecs[15] = '{3'd2, 4'h0, 1'b1, 1'b0, 7'h08, 4'h0};
        vecs[16] = '{3'd2, 4'h0, 1'b0, 1'b1, 7'h04, 4'h0};
        vecs[17] = '{3'd2, 4'h0, 1'b0, 1'b1, 7'h04, 4'h0};
        vecs[18] = '{3'd2, 4'h0, 1'b1, 1'b1, 7'h04, 4'h0};
        vecs[19] = '{3'd2, 4'h0, 1'b1, 1'b0, 7'h04, 4'h0};
        vecs[20] = '{3'd2, 4'h1, 1'b1, 1'b0, 7'h04, 4'h0};
        vecs[21] = '{3'd2, 4'h1, 1'b1, 1'b0, 7'h04, 4'h0};
        vecs[22] = '{3'd2, 4'h1, 1'b1, 1'b0, 7'h04, 4'h0};
        vecs[23] = '{3'd2, 4'h1, 1'b1, 1'b0, 7'h04, 4'h1};
        vecs[24] = '{3'd5, 4'hD, 1'b1, 1'b0, 7'h04, 4'h1};
        vecs[25] = '{3'd5, 4'hD, 1'b1, 1'b0, 7'h04, 4'h1};
        vecs[26] = '{3'd5, 4'hD, 1'b1, 1'b0, 7'h04, 4'h1};
        vecs[27] = '{3'd5, 4'hD, 1'b0, 1'b1, 7'h20, 4'hD};
        vecs[28] = '{3'd5, 4'hD, 1'b0, 1'b1, 7'h20, 4'hD};
        vecs[29] = '{3'd5, 4'hD, 1'b1, 1'b1, 7'h20, 4'hD};
        vecs[30] = '{3'd5, 4'hD, 1'b1, 1'b0, 7'h20, 4'hD};

        for (int i = 0; i < 31; i++) begin
            drive_req(vecs[i].game, vecs[i].opts);
            frame();
            check_all($sformatf("vec%0d", i), vecs[i].exp_rst_n, vecs[i].exp_busy,
                      vecs[i].exp_onehot, vecs[i].exp_opts);
        end

        // user_reset pulse in RUN: chip reset one clk later, game kept.
        bus.user_reset = 1'b1;
        check("urp.pre_rst_n", 32'(bus.chip_reset_n), 32'd1);
        @(negedge clk_sys);
        bus.user_reset = 1'b0;
        check_all("urp.lat", 1'b0, 1'b1, 7'h20, 4'hD);
        frame(); check_all("urp.f1", 1'b0, 1'b1, 7'h20, 4'hD);
        frame(); check_all("urp.f2", 1'b1, 1'b1, 7'h20, 4'hD);
        frame(); check_all("urp.f3", 1'b1, 1'b0, 7'h20, 4'hD);

        // user_reset held 5 frames keeps the chip in reset.
        bus.user_reset = 1'b1;
        for (int f = 0; f < 5; f++) begin
            frame();
            check($sformatf("urh.f%0d.chip_reset_n", f), 32'(bus.chip_reset_n), 32'd0);
        end
        bus.user_reset = 1'b0;
        frame(); check_all("urh.rel", 1'b1, 1'b1, 7'h20, 4'hD);
        frame(); check_all("urh.run", 1'b1, 1'b0, 7'h20, 4'hD);

        // Soccer, then request 7 which clamps to Tennis.
        drive_req(3'd1, 4'hD);
        repeat (4) frame();
        check_all("soc.apply", 1'b0, 1'b1, 7'h02, 4'hD);
        repeat (3) frame();
        check_all("soc.run", 1'b1, 1'b0, 7'h02, 4'hD);
        drive_req(3'd7, 4'hD);
        repeat (3) frame();
        check_all("g7.f3", 1'b1, 1'b0, 7'h02, 4'hD);
        frame();
        check_all("g7.apply", 1'b0, 1'b1, 7'h01, 4'hD);
        repeat (3) frame();
        check_all("g7.run", 1'b1, 1'b0, 7'h01, 4'hD);

        // Block reset in the middle of a chip reset sequence.
        drive_req(3'd6, 4'hD);
        repeat (4) frame();
        check_all("r2.apply", 1'b0, 1'b1, 7'h40, 4'hD);
        reset = 1'b0;
        @(negedge clk_sys);
        check_all("blkrst", 1'b0, 1'b1, 7'h01, 4'h0);
        drive_req(3'd0, 4'h0);
        repeat (3) @(negedge clk_sys);
        reset = 1'b1;

        // Randomized frames against the frame-level model.
        m_game = 0; m_opts = 0; m_gcnt = 0; m_ocnt = 0;
        m_in_rst = 1'b1; m_in_set = 1'b0; m_rst_seen = 0; m_set_seen = 0;
        begin
            int rg, ro, ng, no, sel;
            rg = 0; ro = 0;
            for (int f = 0; f < 80; f++) begin
                sel = int'($urandom_range(0, 9));
                ng = rg; no = ro;
                if (sel < 2) ng = int'($urandom_range(0, 7));
                else if (sel < 4) no = int'($urandom_range(0, 15));
                else if (sel == 4) begin
                    ng = int'($urandom_range(0, 7));
                    no = int'($urandom_range(0, 15));
                end
                if (clampi(ng) != clampi(rg)) m_gcnt = 0;
                if (no != ro) m_ocnt = 0;
                rg = ng; ro = no;
                drive_req(3'(ng), 4'(no));
                if (sel == 5) begin
                    pulse_user_reset();
                    if (!m_in_rst) begin
                        m_in_rst = 1'b1; m_in_set = 1'b0; m_rst_seen = 0;
                        m_gcnt = 0; m_ocnt = 0;
                    end
                end
                frame();
                if (m_in_rst) begin
                    m_rst_seen++;
                    if (m_rst_seen == RESETF) begin
                        m_in_rst = 1'b0; m_in_set = 1'b1; m_set_seen = 0;
                    end
                end else if (m_in_set) begin
                    m_set_seen++;
                    if (m_set_seen == SETTLF) m_in_set = 1'b0;
                end else begin
                    if (no != m_opts) begin
                        m_ocnt++;
                        if (m_ocnt == STABLE) begin m_opts = no; m_ocnt = 0; end
                    end else m_ocnt = 0;
                    if (clampi(ng) != m_game) begin
                        m_gcnt++;
                        if (m_gcnt == STABLE) begin
                            m_game = clampi(ng); m_gcnt = 0; m_ocnt = 0;
                            m_in_rst = 1'b1; m_rst_seen = 0;
                        end
                    end else m_gcnt = 0;
                end
                check_all($sformatf("rnd%0d", f), !m_in_rst, m_in_rst || m_in_set,
                          7'(1 << m_game), 4'(m_opts));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
